// File: rtl/sdram_arbiter_if.sv
// Bundle of the request-side and controller-side signals of the SDRAM
// arbiter. The arbiter uses the slave view; the game core and SDRAM
// controller together use the master view.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4
);
    logic                            download;
    logic                            wr_req;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]           wr_data;
    logic                            wr_ack;
    logic [NUM_PORTS-1:0]            rd_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_PORTS-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]           rd_q;
    logic [ADDR_WIDTH-1:0]           sdram_addr;
    logic [DATA_WIDTH-1:0]           sdram_data;
    logic                            sdram_we;
    logic                            sdram_req;
    logic                            sdram_ack;
    logic                            sdram_valid;
    logic [DATA_WIDTH-1:0]           sdram_q;

    modport slave (
        input  download, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               sdram_ack, sdram_valid, sdram_q,
        output wr_ack, rd_valid, rd_q,
               sdram_addr, sdram_data, sdram_we, sdram_req
    );

    modport master (
        output download, wr_req, wr_addr, wr_data, rd_req, rd_addr,
               sdram_ack, sdram_valid, sdram_q,
        input  wr_ack, rd_valid, rd_q,
               sdram_addr, sdram_data, sdram_we, sdram_req
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between the ROM download writer and
// NUM_PORTS read requesters. Strobes are latched into pending slots; a
// pending write always wins, reads are served round-robin, and only one
// transaction is outstanding at the controller at any time.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4
) (
    input logic         clk,
    input logic         reset_n,
    sdram_arbiter_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]            state_r;
    logic                  wr_pend_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic [NUM_PORTS-1:0]  rd_pend_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r [NUM_PORTS];
    logic [PW-1:0]         last_r;
    logic [PW-1:0]         owner_r;
    logic                  owner_wr_r;

    logic [ADDR_WIDTH-1:0] sdram_addr_r;
    logic [DATA_WIDTH-1:0] sdram_data_r;
    logic                  sdram_we_r;
    logic                  sdram_req_r;
    logic                  wr_ack_r;
    logic [NUM_PORTS-1:0]  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_q_r;

    logic                  sel_found_s;
    logic [PW-1:0]         sel_idx_s;
    logic [PW-1:0]         idx_s;
    logic                  grant_wr_s;
    logic                  grant_rd_s;

    assign bus.sdram_addr = sdram_addr_r;
    assign bus.sdram_data = sdram_data_r;
    assign bus.sdram_we   = sdram_we_r;
    assign bus.sdram_req  = sdram_req_r;
    assign bus.wr_ack     = wr_ack_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_q       = rd_q_r;

    // Round-robin search for the first pending read after the last served port.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = last_r;
        idx_s       = last_r;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx_s       = PW'((int'(last_r) + k) % NUM_PORTS);
            sel_idx_s   = (!sel_found_s && rd_pend_r[idx_s]) ? idx_s : sel_idx_s;
            sel_found_s = sel_found_s | rd_pend_r[idx_s];
        end
        grant_wr_s = (state_r == ST_IDLE) && wr_pend_r;
        grant_rd_s = (state_r == ST_IDLE) && !wr_pend_r && sel_found_s && !bus.download;
    end

    // Pending slots: a new strobe beats the clear of a same-cycle grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
            rd_pend_r <= {NUM_PORTS{1'b0}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_addr_r[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            if (bus.wr_req) begin
                wr_pend_r <= 1'b1;
                wr_addr_r <= bus.wr_addr;
                wr_data_r <= bus.wr_data;
            end else if (grant_wr_s) begin
                wr_pend_r <= 1'b0;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.download) begin
                    rd_pend_r[i] <= 1'b0;
                end else if (bus.rd_req[i]) begin
                    rd_pend_r[i] <= 1'b1;
                    rd_addr_r[i] <= bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end else if (grant_rd_s && (sel_idx_s == PW'(i))) begin
                    rd_pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Transaction FSM driving the controller and returning acks/read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            last_r       <= PW'(NUM_PORTS - 1);
            owner_r      <= {PW{1'b0}};
            owner_wr_r   <= 1'b0;
            sdram_addr_r <= {ADDR_WIDTH{1'b0}};
            sdram_data_r <= {DATA_WIDTH{1'b0}};
            sdram_we_r   <= 1'b0;
            sdram_req_r  <= 1'b0;
            wr_ack_r     <= 1'b0;
            rd_valid_r   <= {NUM_PORTS{1'b0}};
            rd_q_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ack_r   <= 1'b0;
            rd_valid_r <= {NUM_PORTS{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (grant_wr_s) begin
                        sdram_addr_r <= wr_addr_r;
                        sdram_data_r <= wr_data_r;
                        sdram_we_r   <= 1'b1;
                        sdram_req_r  <= 1'b1;
                        owner_wr_r   <= 1'b1;
                        state_r      <= ST_REQ;
                    end else if (grant_rd_s) begin
                        sdram_addr_r <= rd_addr_r[sel_idx_s];
                        sdram_data_r <= {DATA_WIDTH{1'b0}};
                        sdram_we_r   <= 1'b0;
                        sdram_req_r  <= 1'b1;
                        owner_wr_r   <= 1'b0;
                        owner_r      <= sel_idx_s;
                        last_r       <= sel_idx_s;
                        state_r      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        if (owner_wr_r) begin
                            wr_ack_r <= 1'b1;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.sdram_valid) begin
                        rd_q_r     <= bus.sdram_q;
                        rd_valid_r <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner_r;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    sdram_req_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the bench plays the
// game core and the SDRAM controller.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_ack_cnt = 0;
    logic seen_s;

    always #10 clk = ~clk;

    sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd_addr(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.sdram_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " req"}, 64'(bus.sdram_req), 64'd1);
    endtask

    task automatic serve_read(input string tag, input logic [NP-1:0] exp_v,
                              input logic [AW-1:0] exp_a, input logic [DW-1:0] q);
        wait_req(tag);
        chk({tag, " we"},   64'(bus.sdram_we),   64'd0);
        chk({tag, " addr"}, 64'(bus.sdram_addr), 64'(exp_a));
        chk({tag, " data"}, 64'(bus.sdram_data), 64'd0);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk({tag, " req_low"}, 64'(bus.sdram_req), 64'd0);
        tick();
        tick();
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = q;
        tick();
        bus.sdram_valid = 1'b0;
        chk({tag, " rd_valid"}, 64'(bus.rd_valid), 64'(exp_v));
        chk({tag, " rd_q"},     64'(bus.rd_q),     64'(q));
        tick();
        chk({tag, " rd_valid_pulse"}, 64'(bus.rd_valid), 64'd0);
    endtask

    task automatic serve_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_req(tag);
        chk({tag, " we"},   64'(bus.sdram_we),   64'd1);
        chk({tag, " addr"}, 64'(bus.sdram_addr), 64'(a));
        chk({tag, " data"}, 64'(bus.sdram_data), 64'(d));
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        chk({tag, " req_low"}, 64'(bus.sdram_req), 64'd0);
        chk({tag, " wr_ack"},  64'(bus.wr_ack),    64'd1);
        if (bus.wr_ack === 1'b1) begin
            wr_ack_cnt++;
        end
        tick();
        chk({tag, " wr_ack_pulse"}, 64'(bus.wr_ack), 64'd0);
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        bus.download    = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.rd_req      = '0;
        bus.rd_addr     = '0;
        bus.sdram_ack   = 1'b0;
        bus.sdram_valid = 1'b0;
        bus.sdram_q     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        apply_reset();
        reset_n = 1'b0;
        tick();
        chk("rst req",      64'(bus.sdram_req),  64'd0);
        chk("rst we",       64'(bus.sdram_we),   64'd0);
        chk("rst addr",     64'(bus.sdram_addr), 64'd0);
        chk("rst data",     64'(bus.sdram_data), 64'd0);
        chk("rst wr_ack",   64'(bus.wr_ack),     64'd0);
        chk("rst rd_valid", 64'(bus.rd_valid),   64'd0);
        chk("rst rd_q",     64'(bus.rd_q),       64'd0);
        reset_n = 1'b1;
        tick();

        // Single read with exact cycle timing (strobe in cycle 0)
        set_rd_addr(2, 23'h001234);
        bus.rd_req = 4'b0100;
        tick();                                    // cycle 1
        bus.rd_req = 4'b0000;
        chk("t1 c1 req", 64'(bus.sdram_req), 64'd0);
        tick();                                    // cycle 2
        chk("t1 c2 req",  64'(bus.sdram_req),  64'd1);
        chk("t1 c2 we",   64'(bus.sdram_we),   64'd0);
        chk("t1 c2 addr", 64'(bus.sdram_addr), 64'h001234);
        bus.sdram_valid = 1'b1;                    // stray valid in REQ
        bus.sdram_q     = 32'h11111111;
        tick();                                    // cycle 3
        bus.sdram_valid = 1'b0;
        tick();                                    // cycle 4
        chk("t1 stray valid", 64'(bus.rd_valid), 64'd0);
        tick();                                    // cycle 5
        chk("t1 c5 req held", 64'(bus.sdram_req), 64'd1);
        bus.sdram_ack = 1'b1;
        tick();                                    // cycle 6
        bus.sdram_ack = 1'b0;
        chk("t1 c6 req", 64'(bus.sdram_req), 64'd0);
        bus.sdram_ack = 1'b1;                      // stray ack in WAIT
        tick();                                    // cycle 7
        bus.sdram_ack = 1'b0;
        tick();                                    // cycle 8
        tick();                                    // cycle 9
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'hDEADBEEF;
        tick();                                    // cycle 10
        bus.sdram_valid = 1'b0;
        chk("t1 c10 rd_valid", 64'(bus.rd_valid), 64'h4);
        chk("t1 c10 rd_q",     64'(bus.rd_q),     64'hDEADBEEF);
        chk("t1 c10 req",      64'(bus.sdram_req), 64'd0);
        tick();
        chk("t1 c11 rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("t1 c11 rd_q hold", 64'(bus.rd_q),    64'hDEADBEEF);

        // Round-robin from reset: 0,1,2,3 then 0,3
        apply_reset();
        for (int p = 0; p < NP; p++) set_rd_addr(p, 23'(32'h100 + p));
        bus.rd_req = 4'b1111;
        tick();
        bus.rd_req = 4'b0000;
        serve_read("rr p0", 4'b0001, 23'h000100, 32'hA0A0A0A0);
        serve_read("rr p1", 4'b0010, 23'h000101, 32'hA1A1A1A1);
        serve_read("rr p2", 4'b0100, 23'h000102, 32'hA2A2A2A2);
        serve_read("rr p3", 4'b1000, 23'h000103, 32'hA3A3A3A3);
        set_rd_addr(0, 23'h000110);
        set_rd_addr(3, 23'h000113);
        bus.rd_req = 4'b1001;
        tick();
        bus.rd_req = 4'b0000;
        serve_read("rr wrap p0", 4'b0001, 23'h000110, 32'hB0B0B0B0);
        serve_read("rr wrap p3", 4'b1000, 23'h000113, 32'hB3B3B3B3);

        // Write priority over pending reads
        set_rd_addr(1, 23'h000201);
        set_rd_addr(2, 23'h000202);
        bus.rd_req  = 4'b0110;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 23'h000010;
        bus.wr_data = 32'h01020304;
        tick();
        bus.rd_req = 4'b0000;
        bus.wr_req = 1'b0;
        serve_write("wp wr", 23'h000010, 32'h01020304);
        serve_read("wp p1", 4'b0010, 23'h000201, 32'hC1C1C1C1);
        serve_read("wp p2", 4'b0100, 23'h000202, 32'hC2C2C2C2);

        // Download blocking
        set_rd_addr(1, 23'h000301);
        bus.rd_req = 4'b0010;
        tick();
        bus.rd_req = 4'b0000;
        wait_req("dl p1");
        chk("dl p1 addr", 64'(bus.sdram_addr), 64'h000301);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        set_rd_addr(3, 23'h000303);
        bus.rd_req = 4'b1000;
        tick();
        bus.download = 1'b1;
        set_rd_addr(0, 23'h000300);
        bus.rd_req = 4'b0001;
        tick();
        bus.rd_req = 4'b0000;
        tick();
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'h5A5A5A5A;
        tick();
        bus.sdram_valid = 1'b0;
        chk("dl p1 rd_valid", 64'(bus.rd_valid), 64'h2);
        chk("dl p1 rd_q",     64'(bus.rd_q),     64'h5A5A5A5A);
        seen_s = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.rd_req = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            seen_s = seen_s | bus.sdram_req;
        end
        bus.rd_req = 4'b0000;
        chk("dl no read issued", 64'(seen_s), 64'd0);
        wr_ack_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 23'(32'h1000 + i);
            bus.wr_data = 32'(i) * 32'h01010101;
            tick();
            bus.wr_req = 1'b0;
            serve_write("dl wr", 23'(32'h1000 + i), 32'(i) * 32'h01010101);
        end
        chk("dl wr_ack count", 64'(wr_ack_cnt), 64'd100);
        bus.download = 1'b0;
        seen_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_s = seen_s | bus.sdram_req;
        end
        chk("dl p3 dropped", 64'(seen_s), 64'd0);
        chk("dl rd_q hold",  64'(bus.rd_q), 64'h5A5A5A5A);

        // Re-strobe before grant overwrites the address
        bus.wr_req  = 1'b1;
        bus.wr_addr = 23'h000020;
        bus.wr_data = 32'hCAFEF00D;
        tick();
        bus.wr_req = 1'b0;
        set_rd_addr(0, 23'h000400);
        bus.rd_req = 4'b0001;
        tick();
        set_rd_addr(0, 23'h000401);
        tick();
        bus.rd_req = 4'b0000;
        serve_write("rs wr", 23'h000020, 32'hCAFEF00D);
        serve_read("rs p0 B", 4'b0001, 23'h000401, 32'hD0D0D0D0);
        seen_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_s = seen_s | bus.sdram_req;
        end
        chk("rs single read", 64'(seen_s), 64'd0);
        // Strobe during WAIT yields a second read after rd_valid
        set_rd_addr(0, 23'h000410);
        bus.rd_req = 4'b0001;
        tick();
        bus.rd_req = 4'b0000;
        wait_req("rs w1");
        chk("rs w1 addr", 64'(bus.sdram_addr), 64'h000410);
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        set_rd_addr(0, 23'h000420);
        bus.rd_req = 4'b0001;
        tick();
        bus.rd_req = 4'b0000;
        tick();
        bus.sdram_valid = 1'b1;
        bus.sdram_q     = 32'hE1E1E1E1;
        tick();
        bus.sdram_valid = 1'b0;
        chk("rs w1 rd_valid", 64'(bus.rd_valid), 64'h1);
        chk("rs w1 rd_q",     64'(bus.rd_q),     64'hE1E1E1E1);
        chk("rs w1 no req",   64'(bus.sdram_req), 64'd0);
        serve_read("rs w2", 4'b0001, 23'h000420, 32'hE2E2E2E2);

        // Reset in the middle of a write
        bus.wr_req  = 1'b1;
        bus.wr_addr = 23'h000030;
        bus.wr_data = 32'h12345678;
        tick();
        bus.wr_req = 1'b0;
        wait_req("rm");
        #1;
        reset_n = 1'b0;
        #1;
        chk("rm async req", 64'(bus.sdram_req),  64'd0);
        chk("rm async we",  64'(bus.sdram_we),   64'd0);
        chk("rm async addr", 64'(bus.sdram_addr), 64'd0);
        tick();
        reset_n = 1'b1;
        seen_s = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.sdram_ack   = (i % 2 == 0);
            bus.sdram_valid = (i % 2 == 1);
            tick();
            seen_s = seen_s | bus.wr_ack | (|bus.rd_valid) | bus.sdram_req;
        end
        bus.sdram_ack   = 1'b0;
        bus.sdram_valid = 1'b0;
        chk("rm nothing after", 64'(seen_s), 64'd0);
        set_rd_addr(1, 23'h000500);
        bus.rd_req = 4'b0010;
        tick();
        bus.rd_req = 4'b0000;
        serve_read("rm p1", 4'b0010, 23'h000500, 32'hF0F0F0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
